axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI-Lite master bridge. Converts a simple valid/ready command port into AXI-Lite write or read transactions.
- Returns the AXI response (and read data) on a valid/ready response port.
- Sits directly upstream of axi_lite_slave. Its m_axi_* ports connect 1:1 to the slave's s_axi_* ports.
- Used as the RTL stimulus front-end for the register block and as the reference master for the VIP.

Parameters:
- ADDR_WIDTH, 4, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be a multiple of 8.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target byte address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- err_count  out  ERR_CNT_WIDTH  count of non-OKAY responses
- m_axi_awaddr, m_axi_awvalid  out  ADDR_WIDTH, 1  / m_axi_awready  in  1
- m_axi_wdata, m_axi_wstrb, m_axi_wvalid  out  DATA_WIDTH, DATA_WIDTH/8, 1  / m_axi_wready  in  1
- m_axi_bresp  in  2 / m_axi_bvalid  in  1 / m_axi_bready  out  1
- m_axi_araddr, m_axi_arvalid  out  ADDR_WIDTH, 1  / m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH / m_axi_rresp  in  2 / m_axi_rvalid  in  1 / m_axi_rready  out  1

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - State IDLE.
  - All *valid and *ready outputs 0, except cmd_ready, which is 1 out of reset.
  - All address, data, strobe and rsp_* outputs 0; err_count 0.
  - No pending transaction survives reset.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- cmd_ready = 1 only in IDLE. One transaction is outstanding at a time.
- IDLE + command handshake:
  - Register addr, wdata and wstrb into the m_axi payload registers.
  - Write → WR_REQ; the next cycle m_axi_awvalid = m_axi_wvalid = 1.
  - Read → RD_REQ; the next cycle m_axi_arvalid = 1.
- WR_REQ:
  - AW and W are tracked independently with aw_done and w_done flags.
  - Each valid drops the cycle after its own handshake. The other valid is held with a stable payload.
  - When both handshakes are complete (same cycle or different cycles) → WR_RESP with m_axi_bready = 1.
- WR_RESP: on m_axi_bvalid && m_axi_bready:
  - Capture rsp_resp = bresp, rsp_write = 1, rsp_rdata = 0.
  - bready → 0; → RSP.
- RD_REQ: on the AR handshake, arvalid → 0, rready → 1; → RD_DATA.
- RD_DATA: on m_axi_rvalid && m_axi_rready:
  - Capture rsp_rdata = rdata, rsp_resp = rresp, rsp_write = 0.
  - rready → 0; → RSP.
- RSP:
  - rsp_valid = 1; rsp_* held stable until rsp_valid && rsp_ready.
  - Then rsp_valid → 0, cmd_ready → 1; → IDLE.
  - A new command is accepted at the earliest the cycle after the response handshake.
- AXI compliance:
  - No valid depends combinationally on any ready; all m_axi outputs are registered.
  - Once asserted, a valid and its payload stay stable until the handshake.
  - bready and rready are asserted only in WR_RESP and RD_DATA respectively.
- Latency, with ready always high on both sides:
  - Write: cmd handshake at cycle 0; AW/W valid at cycle 1; rsp_valid one cycle after the B handshake.
  - Read: arvalid at cycle 1; rsp_valid one cycle after the R handshake.
- err_count:
  - Increments by 1 when a captured resp ≠ 2'b00.
  - Saturates at all-ones; never wraps.
- A B or R beat arriving outside its own state is ignored (protocol error on the slave side). This is not flagged.

Decomposition:
- Shared package axi_lite_pkg:
  - Response codes RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - State enum typedef axi_lite_mst_state_e.
  - Command and response struct typedefs, parameterised through localparams.
- axi_lite_slave imports the same response codes.
- No sub-module: a single FSM with payload registers is natural at this size.

Test Plan:
- Write then read, back-to-back against axi_lite_slave:
  - Write 0x4, 0xDEADBEEF, strb 0xF → rsp_write = 1, rsp_resp = 00.
  - Read 0x4 → rsp_rdata = 0xDEADBEEF, rsp_resp = 00, err_count = 0.
- Partial strobe:
  - Write 0x8 = 0xFFFFFFFF, then 0x8 = 0x00001234 with strb 0x3.
  - Read 0x8 → 0xFFFF1234.
- Channel skew (BFM slave):
  - awready held low 5 cycles, wready high → wvalid drops after the W handshake; awvalid and awaddr held stable 5 cycles.
  - B is accepted only after the AW handshake; one response is produced.
- Response backpressure:
  - rsp_ready low 3 cycles after a read of 0xC → rsp_valid and rsp_rdata stable, cmd_ready = 0 throughout.
  - The next command is accepted the cycle after the response handshake.
- Errors (BFM slave):
  - Returns SLVERR on write, DECERR on read → rsp_resp = 10 then 11, err_count = 2.
  - 300 error responses → err_count saturates at 255.
- Reset mid-read:
  - Assert rst_n low while in RD_DATA → all valids and readies 0 immediately, cmd_ready = 1 after release.
  - A fresh read of 0x0 returns 0x00000000.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes, master state enum and command/response types
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXIL_ADDR_WIDTH = 4;
    localparam int AXIL_DATA_WIDTH = 32;
    localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } axi_lite_mst_state_e;

    typedef struct packed {
        logic                       write;
        logic [AXIL_ADDR_WIDTH-1:0] addr;
        logic [AXIL_DATA_WIDTH-1:0] wdata;
        logic [AXIL_STRB_WIDTH-1:0] wstrb;
    } axil_cmd_t;

    typedef struct packed {
        logic                       write;
        logic [AXIL_DATA_WIDTH-1:0] rdata;
        logic [1:0]                 resp;
    } axil_rsp_t;

    // Anything other than OKAY counts as an error response.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-Lite master bridge from a cmd/rsp port
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [DATA_WIDTH-1:0]    m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]  m_axi_wstrb,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    axi_lite_mst_state_e state_q, state_d;

    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     arvalid_q, arvalid_d;
    logic                     bready_q, bready_d;
    logic                     rready_q, rready_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]    wstrb_q, wstrb_d;
    logic                     rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]               rsp_resp_q, rsp_resp_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

    logic       capture;
    logic [1:0] capture_resp;
    logic       aw_fin;
    logic       w_fin;

    // State and every AXI-facing output live in flops; nothing below reaches an output combinationally from a ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-register logic; AW and W retire independently and B is only taken once both have.
    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        rready_d     = rready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rsp_write_d  = rsp_write_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;
        capture      = 1'b0;
        capture_resp = RESP_OKAY;
        aw_fin       = aw_done_q || (awvalid_q && m_axi_awready);
        w_fin        = w_done_q || (wvalid_q && m_axi_wready);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid && bready_q) begin
                    rsp_write_d  = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_resp_d   = m_axi_bresp;
                    capture      = 1'b1;
                    capture_resp = m_axi_bresp;
                    bready_d     = 1'b0;
                    state_d      = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid && rready_q) begin
                    rsp_write_d  = 1'b0;
                    rsp_rdata_d  = m_axi_rdata;
                    rsp_resp_d   = m_axi_rresp;
                    capture      = 1'b1;
                    capture_resp = m_axi_rresp;
                    rready_d     = 1'b0;
                    state_d      = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating error counter, stepped on every captured non-OKAY response.
    always_comb begin
        err_d = err_q;
        if (capture && resp_is_err(capture_resp) && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_WIDTH'(1);
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = (state_q == ST_RSP);
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign err_count     = err_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - directed self-checking bench for axi_lite_master with a small slave model
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [1:0]  bresp_cfg = RESP_OKAY;
    logic [1:0]  rresp_cfg = RESP_OKAY;
    logic        r_stall = 1'b0;

    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Slave model: four word registers, B only after both AW and W, R optionally stalled.
    logic [31:0] mem [4];
    logic        aw_got, w_got, ar_pend;
    logic [3:0]  aw_a, ar_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; ar_pend <= 1'b0;
            aw_a <= '0; ar_a <= '0; w_d <= '0; w_s <= '0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (awvalid && awready && !aw_got) begin aw_got <= 1'b1; aw_a <= awaddr; end
            if (wvalid && wready && !w_got) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; end
            if (aw_got && w_got && !bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) mem[aw_a[3:2]][8*b +: 8] <= w_d[8*b +: 8];
                bvalid <= 1'b1; bresp <= bresp_cfg;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin ar_pend <= 1'b1; ar_a <= araddr; end
            if (ar_pend && !rvalid && !r_stall) begin
                rvalid <= 1'b1; rdata <= mem[ar_a[3:2]]; rresp <= rresp_cfg; ar_pend <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called and returns at #1 after a clock edge; on return the command handshake edge has just passed.
    task automatic do_cmd(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) check_eq("cmd_timeout", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic w, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) check_eq("rsp_timeout", rsp_valid, 1);
        w = rsp_write; d = rsp_rdata; r = rsp_resp;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic        g_w;
    logic [31:0] g_d;
    logic [1:0]  g_r;

    initial begin
        // Reset state
        #12;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check_eq("rst_rsp", {rsp_write, rsp_rdata, rsp_resp}, 0);
        check_eq("rst_err", err_count, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back
        do_cmd(1, 4'h4, 32'hDEADBEEF, 4'hF);
        check_eq("wr_aw_w_cycle1", {awvalid, wvalid}, 2'b11);
        get_rsp(g_w, g_d, g_r);
        check_eq("wr1_write", g_w, 1);
        check_eq("wr1_resp", g_r, 2'b00);
        check_eq("wr1_rdata", g_d, 0);
        do_cmd(0, 4'h4, 32'h0, 4'h0);
        check_eq("rd_ar_cycle1", arvalid, 1);
        get_rsp(g_w, g_d, g_r);
        check_eq("rd1_write", g_w, 0);
        check_eq("rd1_data", g_d, 32'hDEADBEEF);
        check_eq("rd1_resp", g_r, 2'b00);
        check_eq("rd1_err", err_count, 0);

        // Partial strobe
        do_cmd(1, 4'h8, 32'hFFFFFFFF, 4'hF); get_rsp(g_w, g_d, g_r);
        do_cmd(1, 4'h8, 32'h00001234, 4'h3); get_rsp(g_w, g_d, g_r);
        do_cmd(0, 4'h8, 32'h0, 4'h0);        get_rsp(g_w, g_d, g_r);
        check_eq("strb_data", g_d, 32'hFFFF1234);

        // Channel skew: awready low for 5 cycles, W goes through first
        awready = 1'b0;
        do_cmd(1, 4'hC, 32'h11223344, 4'hF);
        check_eq("skew_c1", {awvalid, wvalid}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("skew_wvalid_low", wvalid, 0);
            check_eq("skew_aw_hold", {awvalid, awaddr}, {1'b1, 4'hC});
            check_eq("skew_no_bready", bready, 0);
        end
        awready = 1'b1;
        get_rsp(g_w, g_d, g_r);
        check_eq("skew_rsp", {g_w, g_r}, 3'b100);
        @(posedge clk); #1;
        check_eq("skew_single_rsp", rsp_valid, 0);

        // Response backpressure on a read of 0xC, next command right behind the handshake
        do_cmd(0, 4'hC, 32'h0, 4'h0);
        for (int n = 0; n < 200 && !rsp_valid; n++) begin @(posedge clk); #1; end
        check_eq("bp_valid", rsp_valid, 1);
        check_eq("bp_data", rsp_rdata, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", {rsp_valid, rsp_rdata, cmd_ready}, {1'b1, 32'h11223344, 1'b0});
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        check_eq("bp_after_hs", {rsp_valid, cmd_ready, awvalid}, 3'b010);
        @(posedge clk); #1;
        check_eq("bp_next_accepted", {cmd_ready, awvalid}, 2'b01);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        get_rsp(g_w, g_d, g_r);
        check_eq("bp_next_rsp", g_w, 1);

        // Error responses and saturation
        bresp_cfg = RESP_SLVERR;
        do_cmd(1, 4'h0, 32'h0, 4'h0); get_rsp(g_w, g_d, g_r);
        check_eq("err_wr_resp", g_r, 2'b10);
        rresp_cfg = RESP_DECERR;
        do_cmd(0, 4'h4, 32'h0, 4'h0); get_rsp(g_w, g_d, g_r);
        check_eq("err_rd_resp", g_r, 2'b11);
        check_eq("err_count2", err_count, 2);
        rresp_cfg = RESP_OKAY;
        for (int i = 0; i < 298; i++) begin
            do_cmd(1, 4'h0, 32'h0, 4'h0); get_rsp(g_w, g_d, g_r);
            if (i == 252) check_eq("err_reach_max", err_count, 255);
        end
        check_eq("err_saturated", err_count, 255);
        bresp_cfg = RESP_OKAY;

        // Reset while waiting in RD_DATA
        r_stall = 1'b1;
        do_cmd(0, 4'h4, 32'h0, 4'h0);
        for (int n = 0; n < 50 && !rready; n++) begin @(posedge clk); #1; end
        check_eq("rst_mid_rready", rready, 1);
        #2; rst_n = 1'b0; #1;
        check_eq("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check_eq("rst_mid_err", err_count, 0);
        @(posedge clk); #1;
        r_stall = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_cmd_ready", cmd_ready, 1);
        do_cmd(0, 4'h0, 32'h0, 4'h0); get_rsp(g_w, g_d, g_r);
        check_eq("rst_fresh_read", {g_d, g_r}, 34'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
